axi_slice_dc_isolate_ctrl: RTL and testbench

Handshake-level controller placed on the slave (clk_i) side of the AXI dual-clock slice.
- Counts outstanding write and read transactions.
- Limits outstanding transactions to MAX_OUTSTANDING.
- On request, drains the slice: blocks new AW/AR, lets in-flight W/R/B complete, then acknowledges isolation so the far clock domain can be gated or reset safely.
- Only valid/ready/last pass through it. Payload buses bypass the block and connect directly to the slice.

---
 rtl/axi_slice_dc_isolate_ctrl.sv | 94 +++++++++
 tb/tb_axi_slice_dc_isolate_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axi_slice_dc_isolate_ctrl.sv
// axi_slice_dc_isolate_ctrl: gates AW/AR/W handshakes of a dual-clock AXI slice, counts outstanding wr/rd and drains on isolate_req_i before raising isolate_ack_o; R/B are monitored only, status on busy_o/err_o/*_outstanding_o
module axi_slice_dc_isolate_ctrl #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 isolate_req_i,
  output logic                 isolate_ack_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] wr_outstanding_o,
  output logic [CNT_WIDTH-1:0] rd_outstanding_o,
  input  logic                 s_aw_valid_i,
  output logic                 s_aw_ready_o,
  output logic                 m_aw_valid_o,
  input  logic                 m_aw_ready_i,
  input  logic                 s_ar_valid_i,
  output logic                 s_ar_ready_o,
  output logic                 m_ar_valid_o,
  input  logic                 m_ar_ready_i,
  input  logic                 s_w_valid_i,
  input  logic                 s_w_last_i,
  output logic                 s_w_ready_o,
  output logic                 m_w_valid_o,
  input  logic                 m_w_ready_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i
);
  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_OUTSTANDING);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, w_owed_q, w_owed_d;
  logic err_q, err_d, ack_q, ack_d;
  logic allow_aw, allow_ar, allow_w, aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  function automatic logic [CNT_WIDTH-1:0] upd(input logic [CNT_WIDTH-1:0] cnt, input logic inc, input logic dec);
    return (inc && !dec) ? cnt + CNT_WIDTH'(1) :
           (dec && !inc) ? ((cnt == '0) ? '0 : cnt - CNT_WIDTH'(1)) : cnt;
  endfunction
  always_comb begin
    allow_aw = (state_q == RUN) && (wr_cnt_q < MAX_C) && (w_owed_q < MAX_C);
    allow_ar = (state_q == RUN) && (rd_cnt_q < MAX_C);
    allow_w = (w_owed_q != '0);
    m_aw_valid_o = s_aw_valid_i & allow_aw;
    s_aw_ready_o = m_aw_ready_i & allow_aw;
    m_ar_valid_o = s_ar_valid_i & allow_ar;
    s_ar_ready_o = m_ar_ready_i & allow_ar;
    m_w_valid_o = s_w_valid_i & allow_w;
    s_w_ready_o = m_w_ready_i & allow_w;
    aw_hs = s_aw_valid_i & m_aw_ready_i & allow_aw;
    ar_hs = s_ar_valid_i & m_ar_ready_i & allow_ar;
    w_last_hs = s_w_valid_i & m_w_ready_i & allow_w & s_w_last_i;
    b_hs = b_valid_i & b_ready_i;
    r_last_hs = r_valid_i & r_ready_i & r_last_i;
    wr_cnt_d = upd(wr_cnt_q, aw_hs, b_hs);
    rd_cnt_d = upd(rd_cnt_q, ar_hs, r_last_hs);
    w_owed_d = upd(w_owed_q, aw_hs, w_last_hs);
    err_d = err_q | (b_hs & (wr_cnt_q == '0)) | (r_last_hs & (rd_cnt_q == '0));
    state_d = state_q;
    case (state_q)
      RUN: state_d = isolate_req_i ? DRAIN : RUN;
      DRAIN: state_d = !isolate_req_i ? RUN :
                       (wr_cnt_q == '0 && rd_cnt_q == '0 && w_owed_q == '0) ? ISOLATED : DRAIN;
      ISOLATED: state_d = isolate_req_i ? ISOLATED : RUN;
      default: state_d = RUN;
    endcase
    ack_d = (state_d == ISOLATED);
    isolate_ack_o = ack_q;
    err_o = err_q;
    busy_o = (wr_cnt_q | rd_cnt_q | w_owed_q) != '0;
    wr_outstanding_o = wr_cnt_q;
    rd_outstanding_o = rd_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_owed_q <= '0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      w_owed_q <= w_owed_d;
      err_q <= err_d;
      ack_q <= ack_d;
    end
  end
endmodule

// File: tb/tb_axi_slice_dc_isolate_ctrl.sv
// tb_axi_slice_dc_isolate_ctrl: directed self-checking bench for axi_slice_dc_isolate_ctrl
module tb_axi_slice_dc_isolate_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b1, isolate_req_i = 1'b0;
  logic isolate_ack_o, busy_o, err_o;
  logic [3:0] wr_outstanding_o, rd_outstanding_o;
  logic s_aw_valid_i = 0, s_aw_ready_o, m_aw_valid_o, m_aw_ready_i = 0;
  logic s_ar_valid_i = 0, s_ar_ready_o, m_ar_valid_o, m_ar_ready_i = 0;
  logic s_w_valid_i = 0, s_w_last_i = 0, s_w_ready_o, m_w_valid_o, m_w_ready_i = 0;
  logic r_valid_i = 0, r_ready_i = 0, r_last_i = 0, b_valid_i = 0, b_ready_i = 0;
  int n_chk = 0, n_err = 0;
  axi_slice_dc_isolate_ctrl #(.MAX_OUTSTANDING(8), .CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .isolate_req_i(isolate_req_i), .isolate_ack_o(isolate_ack_o),
    .busy_o(busy_o), .err_o(err_o), .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
    .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o), .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o), .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
    .s_w_valid_i(s_w_valid_i), .s_w_last_i(s_w_last_i), .s_w_ready_o(s_w_ready_o), .m_w_valid_o(m_w_valid_o),
    .m_w_ready_i(m_w_ready_i), .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic set_r(input logic v);
    r_valid_i = v; r_ready_i = v; r_last_i = v;
  endtask
  task automatic set_b(input logic v);
    b_valid_i = v; b_ready_i = v;
  endtask
  initial begin
    s_aw_valid_i = 1; m_aw_ready_i = 1; s_w_valid_i = 1; m_w_ready_i = 1;
    tick(); tick();
    chk("rst_ack", isolate_ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wr", wr_outstanding_o, 0);
    chk("rst_rd", rd_outstanding_o, 0);
    chk("rst_aw_ready", s_aw_ready_o, 1);
    chk("rst_aw_valid", m_aw_valid_o, 1);
    chk("rst_w_ready", s_w_ready_o, 0);
    chk("rst_w_valid", m_w_valid_o, 0);
    s_aw_valid_i = 0; s_w_valid_i = 0; m_ar_ready_i = 1;
    rst_i = 0;
    tick();
    isolate_req_i = 1; #1;
    chk("iso_c0_ack", isolate_ack_o, 0);
    tick();
    chk("iso_c1_ack", isolate_ack_o, 0);
    chk("iso_c1_aw_ready", s_aw_ready_o, 0);
    chk("iso_c1_ar_ready", s_ar_ready_o, 0);
    tick();
    chk("iso_c2_ack", isolate_ack_o, 1);
    isolate_req_i = 0;
    tick();
    chk("iso_rel_ack", isolate_ack_o, 0);
    chk("iso_rel_aw_ready", s_aw_ready_o, 1);
    s_aw_valid_i = 1; #1;
    chk("wf_aw_ready", s_aw_ready_o, 1);
    tick();
    s_aw_valid_i = 0;
    chk("wf_wr1", wr_outstanding_o, 1);
    chk("wf_busy1", busy_o, 1);
    s_w_valid_i = 1; #1;
    chk("wf_w_ready", s_w_ready_o, 1);
    tick(); tick(); tick();
    s_w_last_i = 1;
    tick();
    s_w_valid_i = 0; s_w_last_i = 0; #1;
    chk("wf_w_closed", s_w_ready_o, 0);
    chk("wf_wr_after_w", wr_outstanding_o, 1);
    set_b(1); #1;
    chk("wf_busy_at_b", busy_o, 1);
    tick();
    set_b(0);
    chk("wf_wr0", wr_outstanding_o, 0);
    chk("wf_busy0", busy_o, 0);
    s_w_valid_i = 1; s_w_last_i = 1; #1;
    chk("wba_w_stall0", s_w_ready_o, 0);
    tick(); tick(); tick();
    chk("wba_w_stall3", s_w_ready_o, 0);
    s_aw_valid_i = 1; #1;
    chk("wba_w_stall_aw", s_w_ready_o, 0);
    tick();
    s_aw_valid_i = 0; #1;
    chk("wba_w_pass", s_w_ready_o, 1);
    chk("wba_w_mvalid", m_w_valid_o, 1);
    tick();
    s_w_valid_i = 0; s_w_last_i = 0;
    chk("wba_w_done", s_w_ready_o, 0);
    set_b(1);
    tick();
    set_b(0);
    chk("wba_busy0", busy_o, 0);
    s_ar_valid_i = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("lim_rd8", rd_outstanding_o, 8);
    chk("lim_ar_ready", s_ar_ready_o, 0);
    chk("lim_ar_mvalid", m_ar_valid_o, 0);
    set_r(1);
    tick();
    set_r(0); #1;
    chk("lim_rd7", rd_outstanding_o, 7);
    chk("lim_ar_reopen", s_ar_ready_o, 1);
    tick();
    s_ar_valid_i = 0;
    chk("lim_rd8b", rd_outstanding_o, 8);
    set_r(1);
    for (int i = 0; i < 6; i++) tick();
    set_r(0);
    chk("dr_rd2", rd_outstanding_o, 2);
    isolate_req_i = 1;
    tick();
    s_ar_valid_i = 1; #1;
    chk("dr_ar_blocked", s_ar_ready_o, 0);
    chk("dr_ar_mvalid", m_ar_valid_o, 0);
    chk("dr_ack0", isolate_ack_o, 0);
    set_r(1);
    tick();
    chk("dr_rd1", rd_outstanding_o, 1);
    chk("dr_ack1", isolate_ack_o, 0);
    tick();
    set_r(0);
    chk("dr_rd0", rd_outstanding_o, 0);
    chk("dr_ack_zero", isolate_ack_o, 0);
    tick();
    chk("dr_ack_set", isolate_ack_o, 1);
    isolate_req_i = 0; s_ar_valid_i = 0;
    tick();
    chk("dr_ack_clr", isolate_ack_o, 0);
    s_ar_valid_i = 1;
    tick(); tick();
    s_ar_valid_i = 0;
    chk("ab_rd2", rd_outstanding_o, 2);
    isolate_req_i = 1;
    tick();
    chk("ab_drain_ar", s_ar_ready_o, 0);
    isolate_req_i = 0;
    tick();
    chk("ab_run_ar", s_ar_ready_o, 1);
    chk("ab_ack0", isolate_ack_o, 0);
    set_r(1);
    tick(); tick();
    set_r(0);
    chk("ab_rd0", rd_outstanding_o, 0);
    tick();
    chk("ab_ack_never", isolate_ack_o, 0);
    s_aw_valid_i = 1;
    tick();
    chk("sc_wr1", wr_outstanding_o, 1);
    set_b(1);
    tick();
    s_aw_valid_i = 0; set_b(0);
    chk("sc_wr_same", wr_outstanding_o, 1);
    chk("sc_err0", err_o, 0);
    set_b(1);
    tick();
    chk("sc_wr0", wr_outstanding_o, 0);
    chk("sc_err_still0", err_o, 0);
    tick();
    set_b(0);
    chk("err_set", err_o, 1);
    chk("err_wr_floor", wr_outstanding_o, 0);
    chk("err_busy_wowed", busy_o, 1);
    tick();
    chk("err_hold", err_o, 1);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("rst2_err", err_o, 0);
    chk("rst2_busy", busy_o, 0);
    chk("rst2_wr", wr_outstanding_o, 0);
    chk("rst2_rd", rd_outstanding_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
